// File: rtl/vga_pkg.sv
// Shared VGA timing sets, colour and delay-stage types for the raster timing pipeline.
package vga_pkg;

  localparam int CNT_W        = 10;
  localparam int MAX_PIPE_LAT = 15;

  localparam int VGA_640X480_H_SYNC = 96;
  localparam int VGA_640X480_H_BP   = 48;
  localparam int VGA_640X480_H_ACT  = 640;
  localparam int VGA_640X480_H_FP   = 16;
  localparam int VGA_640X480_V_SYNC = 2;
  localparam int VGA_640X480_V_BP   = 33;
  localparam int VGA_640X480_V_ACT  = 480;
  localparam int VGA_640X480_V_FP   = 10;
  localparam logic VGA_640X480_HS_POL = 1'b0;
  localparam logic VGA_640X480_VS_POL = 1'b0;

  localparam int VGA_800X600_H_SYNC = 128;
  localparam int VGA_800X600_H_BP   = 88;
  localparam int VGA_800X600_H_ACT  = 800;
  localparam int VGA_800X600_H_FP   = 40;
  localparam int VGA_800X600_V_SYNC = 4;
  localparam int VGA_800X600_V_BP   = 23;
  localparam int VGA_800X600_V_ACT  = 600;
  localparam int VGA_800X600_V_FP   = 1;
  localparam logic VGA_800X600_HS_POL = 1'b1;
  localparam logic VGA_800X600_VS_POL = 1'b1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } stage_t;

  // Idle stage for the negative-polarity (640x480) sync convention.
  localparam stage_t STAGE_IDLE_NEG = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

  function automatic stage_t idle_stage(input logic hs_pol, input logic vs_pol);
    idle_stage = '{hs: ~hs_pol, vs: ~vs_pol, vis: 1'b0};
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with sync/active region decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int SYNC = 96,
  parameter int BP   = 48,
  parameter int ACT  = 640,
  parameter int FP   = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             i_en,
  output logic             o_wrap,
  output logic             o_in_sync,
  output logic             o_in_active,
  output logic [CNT_W-1:0] o_coord
);

  localparam int TOTAL = SYNC + BP + ACT + FP;
  localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] C_SYNC    = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] C_ACT_BEG = CNT_W'(SYNC + BP);
  localparam logic [CNT_W-1:0] C_ACT_END = CNT_W'(SYNC + BP + ACT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_wrap      = (r_cnt == C_LAST);
  assign o_in_sync   = (r_cnt < C_SYNC);
  assign o_in_active = (r_cnt >= C_ACT_BEG) && (r_cnt < C_ACT_END);
  assign o_coord     = o_in_active ? (r_cnt - C_ACT_BEG) : '0;

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA raster timing generator whose sync/blank outputs are delayed to line up with
// colour returned by a pixel source of fixed latency.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int   H_SYNC   = VGA_640X480_H_SYNC,
  parameter int   H_BP     = VGA_640X480_H_BP,
  parameter int   H_ACT    = VGA_640X480_H_ACT,
  parameter int   H_FP     = VGA_640X480_H_FP,
  parameter int   V_SYNC   = VGA_640X480_V_SYNC,
  parameter int   V_BP     = VGA_640X480_V_BP,
  parameter int   V_ACT    = VGA_640X480_V_ACT,
  parameter int   V_FP     = VGA_640X480_V_FP,
  parameter logic HS_POL   = VGA_640X480_HS_POL,
  parameter logic VS_POL   = VGA_640X480_VS_POL,
  parameter int   COLOR_W  = 8,
  parameter int   PIPE_LAT = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 pix_en,
  output logic [CNT_W-1:0]     x,
  output logic [CNT_W-1:0]     y,
  output logic                 req,
  output logic                 frame_start,
  input  logic [3*COLOR_W-1:0] rgb_in,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 blank,
  output logic [COLOR_W-1:0]   R,
  output logic [COLOR_W-1:0]   G,
  output logic [COLOR_W-1:0]   B
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam stage_t C_IDLE = idle_stage(HS_POL, VS_POL);

  if (H_TOTAL > (1 << CNT_W)) begin : g_chk_h
    $error("vga_timing_pipe: H_TOTAL exceeds counter range");
  end
  if (V_TOTAL > (1 << CNT_W)) begin : g_chk_v
    $error("vga_timing_pipe: V_TOTAL exceeds counter range");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > MAX_PIPE_LAT) begin : g_chk_lat
    $error("vga_timing_pipe: PIPE_LAT out of range 0..15");
  end

  logic             w_h_wrap, w_h_sync, w_h_act;
  logic             w_v_wrap, w_v_sync, w_v_act, w_v_en;
  logic [CNT_W-1:0] w_h_coord, w_v_coord;
  stage_t           w_s0, w_dly_tail;
  stage_t           r_out;
  logic [3*COLOR_W-1:0] r_rgb;
  logic             r_frame_start;

  assign w_v_en = w_h_wrap & pix_en;

  vga_axis_counter #(.SYNC(H_SYNC), .BP(H_BP), .ACT(H_ACT), .FP(H_FP)) u_h_axis (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_en        (pix_en),
    .o_wrap      (w_h_wrap),
    .o_in_sync   (w_h_sync),
    .o_in_active (w_h_act),
    .o_coord     (w_h_coord)
  );

  vga_axis_counter #(.SYNC(V_SYNC), .BP(V_BP), .ACT(V_ACT), .FP(V_FP)) u_v_axis (
    .Clock       (Clock),
    .Reset       (Reset),
    .i_en        (w_v_en),
    .o_wrap      (w_v_wrap),
    .o_in_sync   (w_v_sync),
    .o_in_active (w_v_act),
    .o_coord     (w_v_coord)
  );

  assign req = w_h_act & w_v_act;
  assign x   = req ? w_h_coord : '0;
  assign y   = req ? w_v_coord : '0;

  // High exactly while both counters sit at zero: set on reset and on the frame-wrap tick.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_frame_start <= 1'b1;
    end else if (pix_en) begin
      r_frame_start <= w_h_wrap & w_v_wrap;
    end
  end
  assign frame_start = r_frame_start;

  assign w_s0 = '{hs:  (w_h_sync ? HS_POL : ~HS_POL),
                  vs:  (w_v_sync ? VS_POL : ~VS_POL),
                  vis: req};

  if (PIPE_LAT == 0) begin : g_no_dly
    assign w_dly_tail = w_s0;
  end else begin : g_dly
    stage_t r_dly [PIPE_LAT];

    always_ff @(posedge Clock) begin
      if (Reset) begin
        for (int i = 0; i < PIPE_LAT; i++) r_dly[i] <= C_IDLE;
      end else if (pix_en) begin
        r_dly[0] <= w_s0;
        for (int i = 1; i < PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
      end
    end

    assign w_dly_tail = r_dly[PIPE_LAT-1];
  end

  // rgb_in belongs to the request whose vis bit is at the tail on this tick.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_out <= C_IDLE;
      r_rgb <= '0;
    end else if (pix_en) begin
      r_out <= w_dly_tail;
      r_rgb <= w_dly_tail.vis ? rgb_in : '0;
    end
  end

  assign h_sync = r_out.hs;
  assign v_sync = r_out.vs;
  assign blank  = r_out.vis;
  assign R      = r_rgb[3*COLOR_W-1 -: COLOR_W];
  assign G      = r_rgb[2*COLOR_W-1 -: COLOR_W];
  assign B      = r_rgb[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Directed bench: default 640x480 instance with a latency-1 source model, plus a tiny
// positive-polarity pass-through instance for whole-frame and pix_en-gating checks.
module tb_vga_timing_pipe;
  import vga_pkg::*;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst_a = 1'b1, en_a = 1'b1;
  logic [23:0] rgb_a = '0;
  logic [9:0]  x_a, y_a;
  logic        req_a, fs_a, hs_a, vs_a, bl_a;
  logic [7:0]  r_a, g_a, b_a;

  logic        rst_b = 1'b1, en_b = 1'b1;
  logic [23:0] rgb_b = 24'h123456;
  logic [9:0]  x_b, y_b;
  logic        req_b, fs_b, hs_b, vs_b, bl_b;
  logic [7:0]  r_b, g_b, b_b;

  vga_timing_pipe u_a (
    .Clock(Clock), .Reset(rst_a), .pix_en(en_a),
    .x(x_a), .y(y_a), .req(req_a), .frame_start(fs_a), .rgb_in(rgb_a),
    .h_sync(hs_a), .v_sync(vs_a), .blank(bl_a), .R(r_a), .G(g_a), .B(b_a)
  );

  vga_timing_pipe #(
    .H_SYNC(4), .H_BP(2), .H_ACT(8), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACT(4), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .PIPE_LAT(0)
  ) u_b (
    .Clock(Clock), .Reset(rst_b), .pix_en(en_b),
    .x(x_b), .y(y_b), .req(req_b), .frame_start(fs_b), .rgb_in(rgb_b),
    .h_sync(hs_b), .v_sync(vs_b), .blank(bl_b), .R(r_b), .G(g_b), .B(b_b)
  );

  // Source model for instance A: answers each request one enabled tick later.
  logic [9:0] cap_x, cap_y;
  task automatic tick();
    rgb_t pat;
    cap_x = x_a;
    cap_y = y_a;
    @(posedge Clock);
    #1;
    if (en_a) begin
      pat   = '{r: cap_x[7:0], g: cap_y[7:0], b: 8'hA5};
      rgb_a = pat;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    tick(); tick();
    n_checks++; if (hs_a !== 1'b1) begin n_fail++; $display("FAIL reset_hs_a: got %b want 1", hs_a); end
    n_checks++; if (vs_a !== 1'b1) begin n_fail++; $display("FAIL reset_vs_a: got %b want 1", vs_a); end
    n_checks++; if (bl_a !== 1'b0) begin n_fail++; $display("FAIL reset_blank_a: got %b want 0", bl_a); end
    n_checks++; if ({r_a, g_a, b_a} !== 24'h0) begin n_fail++; $display("FAIL reset_rgb_a: got %h want 000000", {r_a, g_a, b_a}); end
    n_checks++; if (fs_a !== 1'b1) begin n_fail++; $display("FAIL reset_fs_a: got %b want 1", fs_a); end
    n_checks++; if ({x_a, y_a, req_a} !== 21'h0) begin n_fail++; $display("FAIL reset_xy_a: got x=%0d y=%0d req=%b want 0 0 0", x_a, y_a, req_a); end
    n_checks++; if ({hs_b, vs_b, bl_b} !== 3'b000) begin n_fail++; $display("FAIL reset_sync_b: got %b want 000", {hs_b, vs_b, bl_b}); end
    n_checks++; if ({x_b, y_b, req_b} !== 21'h0) begin n_fail++; $display("FAIL reset_xy_b: got x=%0d y=%0d req=%b want 0 0 0", x_b, y_b, req_b); end
    rst_a = 1'b0; rst_b = 1'b0;
  endtask

  task automatic test_first_pixel();
    int n = 0;
    while (req_a !== 1'b1 && n < 30000) begin tick(); n++; end
    n_checks++; if (n != 28144) begin n_fail++; $display("FAIL first_req_ticks: got %0d want 28144", n); end
    n_checks++; if (x_a !== 10'd0 || y_a !== 10'd0) begin n_fail++; $display("FAIL first_xy: got x=%0d y=%0d want 0 0", x_a, y_a); end
    tick();
    n_checks++; if (bl_a !== 1'b0) begin n_fail++; $display("FAIL blank_lat1: got %b want 0", bl_a); end
    tick();
    n_checks++; if (bl_a !== 1'b1) begin n_fail++; $display("FAIL blank_lat2: got %b want 1", bl_a); end
    n_checks++; if ({r_a, g_a, b_a} !== 24'h0000A5) begin n_fail++; $display("FAIL rgb_blank_rise: got %h want 0000a5", {r_a, g_a, b_a}); end
  endtask

  task automatic test_line_end();
    int vis = 0;
    logic [23:0] last = '0;
    while (bl_a === 1'b1 && vis < 1000) begin
      last = {r_a, g_a, b_a};
      tick();
      vis++;
    end
    n_checks++; if (vis != 640) begin n_fail++; $display("FAIL visible_width: got %0d want 640", vis); end
    n_checks++; if (last !== 24'h7F00A5) begin n_fail++; $display("FAIL rgb_blank_fall: got %h want 7f00a5", last); end
    n_checks++; if ({r_a, g_a, b_a} !== 24'h0) begin n_fail++; $display("FAIL rgb_forced_zero: got %h want 000000", {r_a, g_a, b_a}); end
  endtask

  task automatic test_hsync_width();
    int low = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (hs_a === 1'b0) low++;
    end
    n_checks++; if (low != 96) begin n_fail++; $display("FAIL hsync_low_per_line: got %0d want 96", low); end
    n_checks++; if (vs_a !== 1'b1) begin n_fail++; $display("FAIL vsync_idle_line35: got %b want 1", vs_a); end
  endtask

  task automatic test_reset_mid_sync();
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int i = 0; i < 850; i++) tick();
    n_checks++; if (hs_a !== 1'b0 || vs_a !== 1'b0) begin n_fail++; $display("FAIL pre_reset_sync: got hs=%b vs=%b want 0 0", hs_a, vs_a); end
    rst_a = 1'b1; en_a = 1'b0;
    tick();
    n_checks++; if ({hs_a, vs_a, bl_a} !== 3'b110) begin n_fail++; $display("FAIL mid_reset_sync: got %b want 110", {hs_a, vs_a, bl_a}); end
    n_checks++; if ({r_a, g_a, b_a} !== 24'h0) begin n_fail++; $display("FAIL mid_reset_rgb: got %h want 000000", {r_a, g_a, b_a}); end
    n_checks++; if (fs_a !== 1'b1) begin n_fail++; $display("FAIL mid_reset_fs: got %b want 1", fs_a); end
    rst_a = 1'b0; en_a = 1'b1;
  endtask

  task automatic test_tiny_frame();
    int cyc = 0, hs16 = 0, hs_hi = 0, vs_hi = 0, bl_hi = 0, rq_hi = 0, bad_rgb = 0;
    rst_b = 1'b1; en_b = 1'b1; tick(); rst_b = 1'b0;
    while (cyc < 500) begin
      tick(); cyc++;
      if (hs_b === 1'b1) begin hs_hi++; if (cyc <= 16) hs16++; end
      if (vs_b === 1'b1) vs_hi++;
      if (req_b === 1'b1) rq_hi++;
      if (bl_b === 1'b1) begin
        bl_hi++;
        if ({r_b, g_b, b_b} !== 24'h123456) bad_rgb++;
      end else if ({r_b, g_b, b_b} !== 24'h0) bad_rgb++;
      if (fs_b === 1'b1) break;
    end
    n_checks++; if (cyc != 112) begin n_fail++; $display("FAIL tiny_frame_period: got %0d want 112", cyc); end
    n_checks++; if (hs16 != 4) begin n_fail++; $display("FAIL tiny_hsync_per_line: got %0d want 4", hs16); end
    n_checks++; if (hs_hi != 28) begin n_fail++; $display("FAIL tiny_hsync_per_frame: got %0d want 28", hs_hi); end
    n_checks++; if (vs_hi != 16) begin n_fail++; $display("FAIL tiny_vsync_per_frame: got %0d want 16", vs_hi); end
    n_checks++; if (bl_hi != 32) begin n_fail++; $display("FAIL tiny_visible_per_frame: got %0d want 32", bl_hi); end
    n_checks++; if (rq_hi != 32) begin n_fail++; $display("FAIL tiny_req_per_frame: got %0d want 32", rq_hi); end
    n_checks++; if (bad_rgb != 0) begin n_fail++; $display("FAIL tiny_rgb_gating: got %0d bad samples want 0", bad_rgb); end
  endtask

  task automatic test_pix_en_toggle();
    int cyc = 0, rises = 0, start = 0, period = 0, hs_hi = 0, bl_hi = 0;
    logic prev;
    rst_b = 1'b1; en_b = 1'b0; tick(); rst_b = 1'b0;
    n_checks++; if ({fs_b, hs_b, bl_b} !== 3'b100) begin n_fail++; $display("FAIL reset_over_pix_en: got %b want 100", {fs_b, hs_b, bl_b}); end
    prev = fs_b;
    while (rises < 2 && cyc < 2000) begin
      en_b = ~en_b;
      tick(); cyc++;
      if (rises == 1) begin
        if (hs_b === 1'b1) hs_hi++;
        if (bl_b === 1'b1) bl_hi++;
      end
      if (fs_b === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (rises == 1) start = cyc; else period = cyc - start;
      end
      prev = fs_b;
    end
    en_b = 1'b1;
    n_checks++; if (period != 224) begin n_fail++; $display("FAIL toggle_frame_period: got %0d want 224", period); end
    n_checks++; if (hs_hi != 56) begin n_fail++; $display("FAIL toggle_hsync_hold: got %0d want 56", hs_hi); end
    n_checks++; if (bl_hi != 64) begin n_fail++; $display("FAIL toggle_blank_hold: got %0d want 64", bl_hi); end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line_end();
    test_hsync_width();
    test_reset_mid_sync();
    test_tiny_frame();
    test_pix_en_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
